// File: rtl/cdc_pkg.sv
// rtl/cdc_pkg.sv - shared types and constants for the req/ack crossing blocks
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } cdc_hs_state_t;

  // Fewer than two flops on an asynchronous input is never allowed
  localparam int CDC_SYNC_N_MIN = 2;

endpackage

// File: rtl/sync_ff_ar.sv
// rtl/sync_ff_ar.sv - multi-flop synchronizer with asynchronous active-high reset
module sync_ff_ar #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] ff [DEPTH];

  // Shift the asynchronous input through DEPTH flops; all clear on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ff[i] <= '0;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < DEPTH; i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[DEPTH-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// rtl/cdc_hs_tx.sv - source side of a 4-phase req/ack crossing; CDC_HS_TX_SKID_EN adds a one-word skid
module cdc_hs_tx #(
  parameter int W      = 32,
  parameter int SYNC_N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         in_rdy,
  output logic         cdc_req,
  output logic [W-1:0] cdc_data,
  input  logic         cdc_ack,
  output logic         busy
);

  import cdc_pkg::*;

  // Clamp so a mis-set parameter still yields a safe synchronizer depth
  localparam int SYNC_D = (SYNC_N < CDC_SYNC_N_MIN) ? CDC_SYNC_N_MIN : SYNC_N;

  cdc_hs_state_t state, state_nxt;
  logic          ack_s;
  logic          take;
  logic          have_word;
  logic [W-1:0]  word;
  logic          launch;

  sync_ff_ar #(
    .WIDTH (1),
    .DEPTH (SYNC_D)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (cdc_ack),
    .q   (ack_s)
  );

`ifdef CDC_HS_TX_SKID_EN
  logic         skid_vld;
  logic [W-1:0] skid_data;
  logic         skid_load;

  // In IDLE a full skid drains this cycle, so a new word can take its place
  assign in_rdy    = !skid_vld || (state == IDLE);
  assign take      = in_vld && in_rdy;
  assign have_word = skid_vld || take;
  assign word      = skid_vld ? skid_data : in_data;
  assign skid_load = take && ((state != IDLE) || skid_vld);

  // Park words that arrive while a transfer is in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_vld  <= 1'b0;
      skid_data <= '0;
    end else if (skid_load) begin
      skid_vld  <= 1'b1;
      skid_data <= in_data;
    end else if (state == IDLE) begin
      skid_vld  <= 1'b0;
    end
  end
`else
  assign in_rdy    = (state == IDLE);
  assign take      = in_vld && in_rdy;
  assign have_word = take;
  assign word      = in_data;
`endif

  assign busy = (state != IDLE);

  // Next-state decode: launch from IDLE, wait for ack high, then ack low
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      IDLE: begin
        if (have_word) begin
          launch    = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ:     if (ack_s)  state_nxt = REL;
      REL:     if (!ack_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, request flop and held crossing data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cdc_req  <= 1'b0;
      cdc_data <= '0;
    end else begin
      state   <= state_nxt;
      cdc_req <= (state_nxt == REQ);
      if (launch) cdc_data <= word;
    end
  end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// tb/tb_cdc_hs_tx.sv - self-checking bench for cdc_hs_tx with a word scoreboard
module tb_cdc_hs_tx;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_vld = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_rdy, cdc_req, busy;
  logic [W-1:0] cdc_data;
  logic         cdc_ack;
  logic         man_ack = 1'b0;
  logic         dst_ack = 1'b0;
  logic         auto_ack = 1'b0;

  logic         vld3 = 1'b0;
  logic [W-1:0] data3 = '0;
  logic         rdy3, req3, busy3;
  logic [W-1:0] cdata3;
  logic         ack3 = 1'b0;

  int           n_chk = 0;
  int           n_fail = 0;
  int           n_hs = 0;
  logic         req_d = 1'b0;
  logic [W-1:0] sb_q [$];

  assign cdc_ack = auto_ack ? dst_ack : man_ack;

  always #5 clk = ~clk;

  cdc_hs_tx #(.W(W), .SYNC_N(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_data  (in_data),
    .in_rdy   (in_rdy),
    .cdc_req  (cdc_req),
    .cdc_data (cdc_data),
    .cdc_ack  (cdc_ack),
    .busy     (busy)
  );

  cdc_hs_tx #(.W(W), .SYNC_N(3)) dut3 (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (vld3),
    .in_data  (data3),
    .in_rdy   (rdy3),
    .cdc_req  (req3),
    .cdc_data (cdata3),
    .cdc_ack  (ack3),
    .busy     (busy3)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: push accepted words, pop and compare on each cdc_req rise
  always @(negedge clk) begin
    if (!rst) begin
      if (in_vld && in_rdy) sb_q.push_back(in_data);
      if (cdc_req && !req_d) begin
        n_hs++;
        if (sb_q.size() == 0) chk("sb_nonempty", 32'(sb_q.size()), 32'd1);
        else chk("sb_data", cdc_data, sb_q.pop_front());
      end
    end
    req_d = cdc_req;
  end

  // Destination model: ack follows req after a 5-cycle delay each way
  initial begin
    forever begin
      @(negedge clk);
      if (auto_ack && cdc_req && !dst_ack) begin
        repeat (5) @(posedge clk);
        #1 dst_ack = 1'b1;
      end else if (auto_ack && !cdc_req && dst_ack) begin
        repeat (5) @(posedge clk);
        #1 dst_ack = 1'b0;
      end
    end
  end

  task automatic send(input logic [W-1:0] w);
    int t;
    in_vld  = 1'b1;
    in_data = w;
    t = 0;
    @(negedge clk);
    while (!in_rdy && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("send_rdy", 32'(in_rdy), 32'd1);
    @(posedge clk);
    #1 in_vld = 1'b0;
  endtask

  initial begin
    int           t;
    int           hs0;
    longint       t0;
    longint       dt;
    logic [W-1:0] w;

    // Reset values
    @(negedge clk);
    chk("rst_req",  32'(cdc_req), 32'd0);
    chk("rst_data", cdc_data,     32'd0);
    chk("rst_busy", 32'(busy),    32'd0);
    chk("rst_rdy",  32'(in_rdy),  32'd1);
    chk("rst_req3", 32'(req3),    32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single transfer with manual ack and data stability
    in_vld  = 1'b1;
    in_data = 32'hDEADBEEF;
    for (int e = 0; e <= 11; e++) begin
      @(posedge clk);
      #1;
      if (e < 11) begin
        in_vld  = 1'b1;
        in_data = $urandom;
      end else begin
        in_vld = 1'b0;
      end
      if (e == 3) man_ack = 1'b1;
      if (e == 8) man_ack = 1'b0;
      @(negedge clk);
      chk("stable_data", cdc_data, 32'hDEADBEEF);
      if (e == 0)  chk("req_rise", 32'(cdc_req), 32'd1);
      if (e <= 10) chk("rdy_low",  32'(in_rdy),  32'd0);
      if (e == 5)  chk("req_hold", 32'(cdc_req), 32'd1);
      if (e == 6)  chk("req_fall", 32'(cdc_req), 32'd0);
      if (e == 11) begin
        chk("rdy_back",  32'(in_rdy), 32'd1);
        chk("busy_done", 32'(busy),   32'd0);
      end
    end
    @(posedge clk);
    #1;

    // Back-pressure: three words against a slow destination
    auto_ack = 1'b1;
    hs0 = n_hs;
    send(32'd1);
    send(32'd2);
    send(32'd3);
    t = 0;
    while ((busy || cdc_ack || cdc_req) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("bp_drain",  32'(busy || cdc_ack || cdc_req), 32'd0);
    chk("bp_hs",     32'(n_hs - hs0), 32'd3);
    chk("bp_sb_emp", 32'(sb_q.size()), 32'd0);
    chk("bp_last",   cdc_data, 32'd3);
    auto_ack = 1'b0;
    @(posedge clk);
    #1;

    // Asynchronous ack at random phases on the SYNC_N=3 instance
    for (int k = 0; k < 4; k++) begin
      w     = $urandom;
      vld3  = 1'b1;
      data3 = w;
      @(posedge clk);
      #1 vld3 = 1'b0;
      @(negedge clk);
      chk("j_req",  32'(req3), 32'd1);
      chk("j_data", cdata3, w);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #($urandom_range(1, 9)) ack3 = 1'b1;
      t0 = $time;
      t = 0;
      while (req3 && t < 50) begin
        @(posedge clk);
        #1;
        t++;
      end
      dt = $time - 1 - t0;
      chk("j_lat", 32'(dt >= 30 && dt <= 40), 32'd1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #($urandom_range(1, 9)) ack3 = 1'b0;
      t = 0;
      while (!rdy3 && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk("j_rdy",   32'(rdy3), 32'd1);
      chk("j_hold",  cdata3, w);
      chk("j_nox",   32'((^{req3, busy3, rdy3, cdata3}) !== 1'bx), 32'd1);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of a request
    in_vld  = 1'b1;
    in_data = 32'hA5A50001;
    @(posedge clk);
    #1 in_vld = 1'b0;
    @(negedge clk);
    chk("mid_req", 32'(cdc_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req",  32'(cdc_req), 32'd0);
    chk("mid_rst_busy", 32'(busy),    32'd0);
    chk("mid_rst_rdy",  32'(in_rdy),  32'd1);
    chk("mid_rst_data", cdc_data,     32'd0);
    sb_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
